// File: rtl/spi_echo_ctrl.sv
// spi_echo_ctrl: SPI slave controller (mode CPOL=0, MOSI captured on sclk fall,
// MISO launched on sclk rise) fully clocked on the system clock.
// The first byte of each frame is a command: ECHO (0x01), WRITE (0x02), READ (0x03).
// Ports:
//   clk, rst_n              system clock, async active-low reset
//   spi_sclk/cs/mosi        raw SPI pins (asynchronous to clk)
//   spi_miso                slave-out data, MSB first
//   rx_data / rx_valid      last data byte and its one-cycle strobe
//   cmd / cmd_valid         last command byte and its one-cycle strobe
//   ctrl_reg / reg_wr       control register and its write strobe
//   err_count               saturating count of bad opcodes and aborted bytes
module spi_echo_ctrl #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] IDLE_RESP = WIDTH'(8'hA5),
    parameter logic [WIDTH-1:0] ERR_RESP  = WIDTH'(8'hFF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spi_sclk,
    input  logic             spi_cs,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic [WIDTH-1:0] cmd,
    output logic             cmd_valid,
    output logic [WIDTH-1:0] ctrl_reg,
    output logic             reg_wr,
    output logic [7:0]       err_count
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] OP_ECHO  = WIDTH'(1);
    localparam logic [WIDTH-1:0] OP_WR    = WIDTH'(2);
    localparam logic [WIDTH-1:0] OP_RD    = WIDTH'(3);
    localparam logic [7:0]       ERR_MAX  = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ECHO,
        S_WR,
        S_RD,
        S_DONE,
        S_IGNORE
    } state_t;

    // Pin synchronisers plus history stage for edge detection.
    logic       sclk_meta, sclk_s, sclk_prev;
    logic       cs_meta, cs_s, cs_prev;
    logic       mosi_meta, mosi_s;
    // Fills with ones after reset; edges are only trusted once every stage
    // holds a real pin sample, so reset values never look like an edge.
    logic [2:0] sync_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_meta <= 1'b0;
            sclk_s    <= 1'b0;
            sclk_prev <= 1'b0;
            cs_meta   <= 1'b0;
            cs_s      <= 1'b0;
            cs_prev   <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_s    <= 1'b0;
            sync_vld  <= 3'b000;
        end else begin
            sclk_meta <= spi_sclk;
            sclk_s    <= sclk_meta;
            sclk_prev <= sclk_s;
            cs_meta   <= spi_cs;
            cs_s      <= cs_meta;
            cs_prev   <= cs_s;
            mosi_meta <= spi_mosi;
            mosi_s    <= mosi_meta;
            sync_vld  <= {sync_vld[1:0], 1'b1};
        end
    end

    logic sclk_fall, sclk_rise, cs_fall, cs_rise, cs_on;

    assign sclk_fall = sync_vld[2] &  sclk_prev & ~sclk_s;
    assign sclk_rise = sync_vld[2] & ~sclk_prev &  sclk_s;
    assign cs_fall   = sync_vld[2] &  cs_prev   & ~cs_s;
    assign cs_rise   = sync_vld[2] & ~cs_prev   &  cs_s;
    assign cs_on     = ~cs_s;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]   rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0]   tx_shift_q, tx_shift_d;
    logic               miso_q, miso_d;
    logic               byte_done_q, byte_done_d;
    logic [WIDTH-1:0]   byte_q, byte_d;
    logic [WIDTH-1:0]   rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic [WIDTH-1:0]   cmd_q, cmd_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic [WIDTH-1:0]   ctrl_q, ctrl_d;
    logic               reg_wr_q, reg_wr_d;
    logic [7:0]         err_q, err_d;
    logic               err_inc;
    logic               in_frame;
    logic [WIDTH-1:0]   rx_next;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            miso_q      <= 1'b0;
            byte_done_q <= 1'b0;
            byte_q      <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            ctrl_q      <= '0;
            reg_wr_q    <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            miso_q      <= miso_d;
            byte_done_q <= byte_done_d;
            byte_q      <= byte_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            ctrl_q      <= ctrl_d;
            reg_wr_q    <= reg_wr_d;
            err_q       <= err_d;
        end
    end

    // Next-state, shift paths and command sequencing.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        miso_d      = miso_q;
        byte_done_d = 1'b0;
        byte_d      = byte_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        ctrl_d      = ctrl_q;
        reg_wr_d    = 1'b0;
        err_d       = err_q;
        err_inc     = 1'b0;
        in_frame    = (state_q != S_IDLE) && cs_on;
        rx_next     = {rx_shift_q[WIDTH-2:0], mosi_s};

        // sclk edges coinciding with a cs deassert are dropped.
        if (in_frame && !cs_rise) begin
            if (sclk_fall) begin
                rx_shift_d = rx_next;
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d   = '0;
                    byte_done_d = 1'b1;
                    byte_d      = rx_next;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            if (sclk_rise) begin
                miso_d     = tx_shift_q[WIDTH-1];
                tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
            end
        end

        // Completed byte: act on it and load the response for the next byte.
        if (byte_done_q) begin
            case (state_q)
                S_CMD: begin
                    cmd_d       = byte_q;
                    cmd_valid_d = 1'b1;
                    case (byte_q)
                        OP_ECHO: begin state_d = S_ECHO; tx_shift_d = OP_ECHO; end
                        OP_WR:   begin state_d = S_WR;   tx_shift_d = OP_WR;   end
                        OP_RD:   begin state_d = S_RD;   tx_shift_d = ctrl_q;  end
                        default: begin
                            state_d    = S_IGNORE;
                            tx_shift_d = ERR_RESP;
                            err_inc    = 1'b1;
                        end
                    endcase
                end
                S_ECHO: begin
                    rx_data_d  = byte_q;
                    rx_valid_d = 1'b1;
                    tx_shift_d = byte_q;
                end
                S_WR: begin
                    ctrl_d     = byte_q;
                    reg_wr_d   = 1'b1;
                    rx_data_d  = byte_q;
                    rx_valid_d = 1'b1;
                    tx_shift_d = byte_q;
                    state_d    = S_DONE;
                end
                S_RD: begin
                    rx_data_d  = byte_q;
                    rx_valid_d = 1'b1;
                    tx_shift_d = '0;
                    state_d    = S_DONE;
                end
                S_DONE:   tx_shift_d = '0;
                S_IGNORE: tx_shift_d = ERR_RESP;
                default:  ;
            endcase
        end

        // Frame start.
        if (state_q == S_IDLE && cs_fall) begin
            state_d    = S_CMD;
            tx_shift_d = IDLE_RESP;
            bit_cnt_d  = '0;
            rx_shift_d = '0;
        end

        // Frame end overrides everything above; a partial byte counts as an error.
        if (cs_rise) begin
            state_d    = S_IDLE;
            bit_cnt_d  = '0;
            rx_shift_d = '0;
            tx_shift_d = '0;
            miso_d     = 1'b0;
            if (bit_cnt_q != '0) begin
                err_inc = 1'b1;
            end
        end

        // A single increment per cycle even if two error sources coincide.
        if (err_inc && err_q != ERR_MAX) begin
            err_d = err_q + 8'd1;
        end
    end

    assign spi_miso  = miso_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign cmd       = cmd_q;
    assign cmd_valid = cmd_valid_q;
    assign ctrl_reg  = ctrl_q;
    assign reg_wr    = reg_wr_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_spi_echo_ctrl.sv
// tb_spi_echo_ctrl: directed bench for spi_echo_ctrl. A bit-banged SPI master
// drives frames at sclk = clk/8; a transaction model of the command protocol
// fills MISO and rx_data scoreboards that are drained as the DUT responds.
module tb_spi_echo_ctrl;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       spi_sclk = 1'b0;
    logic       spi_cs   = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] cmd;
    logic       cmd_valid;
    logic [7:0] ctrl_reg;
    logic       reg_wr;
    logic [7:0] err_count;

    spi_echo_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_sclk  (spi_sclk),
        .spi_cs    (spi_cs),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .ctrl_reg  (ctrl_reg),
        .reg_wr    (reg_wr),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] miso_exp[$];
    logic [7:0] rx_exp[$];
    logic [7:0] m_ctrl  = 8'h00;
    logic [7:0] m_err   = 8'h00;
    logic [7:0] exp_cmd = 8'h00;
    int         rx_cnt  = 0;
    int         cmd_cnt = 0;
    int         wr_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor, sampled on the falling clk edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                rx_cnt++;
                if (rx_exp.size() != 0) chk("rx_data", 32'(rx_data), 32'(rx_exp.pop_front()));
                else                    chk("rx_spurious", 32'(rx_valid), 32'd0);
            end
            if (cmd_valid) begin
                cmd_cnt++;
                chk("cmd", 32'(cmd), 32'(exp_cmd));
            end
            if (reg_wr) begin
                wr_cnt++;
                chk("ctrl_on_wr", 32'(ctrl_reg), 32'(m_ctrl));
            end
        end
    end

    // Protocol model: pushes the MISO byte returned during each MOSI byte.
    task automatic model_frame(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] b[3];
        logic [7:0] tx;
        int         st;
        b  = '{b0, b1, b2};
        tx = 8'hA5;
        st = 0;
        for (int i = 0; i < n; i++) begin
            miso_exp.push_back(tx);
            case (st)
                0: begin
                    exp_cmd = b[i];
                    case (b[i])
                        8'h01:   begin st = 1; tx = 8'h01;  end
                        8'h02:   begin st = 2; tx = 8'h02;  end
                        8'h03:   begin st = 3; tx = m_ctrl; end
                        default: begin
                            st = 5;
                            tx = 8'hFF;
                            if (m_err != 8'hFF) m_err = m_err + 8'd1;
                        end
                    endcase
                end
                1: begin rx_exp.push_back(b[i]); tx = b[i]; end
                2: begin m_ctrl = b[i]; rx_exp.push_back(b[i]); tx = b[i]; st = 4; end
                3: begin rx_exp.push_back(b[i]); tx = 8'h00; st = 4; end
                4: tx = 8'h00;
                default: tx = 8'hFF;
            endcase
        end
    endtask

    // Master shifts n bits MSB first; MISO is sampled at the end of each low phase.
    task automatic spi_bits(input logic [7:0] d, input int n, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi_sclk = 1'b1;
            spi_mosi = d[7-i];
            #40;
            spi_sclk = 1'b0;
            #40;
            r = {r[6:0], spi_miso};
        end
    endtask

    task automatic xfer_checked(input logic [7:0] d);
        logic [7:0] r;
        spi_bits(d, 8, r);
        if (miso_exp.size() != 0) chk("miso", 32'(r), 32'(miso_exp.pop_front()));
        else                      chk("miso_unscored", 32'(r), 32'hFFFF_FFFF);
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        #80;
    endtask

    task automatic cs_high();
        #40;
        spi_cs = 1'b1;
        #120;
    endtask

    task automatic run_frame(input int n, input logic [7:0] b0,
                             input logic [7:0] b1 = 8'h00, input logic [7:0] b2 = 8'h00);
        logic [7:0] b[3];
        b = '{b0, b1, b2};
        model_frame(n, b0, b1, b2);
        cs_low();
        for (int i = 0; i < n; i++) xfer_checked(b[i]);
        cs_high();
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_miso"},      32'(spi_miso),  32'd0);
        chk({pfx, "_rx_data"},   32'(rx_data),   32'd0);
        chk({pfx, "_rx_valid"},  32'(rx_valid),  32'd0);
        chk({pfx, "_cmd"},       32'(cmd),       32'd0);
        chk({pfx, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
        chk({pfx, "_ctrl_reg"},  32'(ctrl_reg),  32'd0);
        chk({pfx, "_reg_wr"},    32'(reg_wr),    32'd0);
        chk({pfx, "_err_count"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        int         rx0;
        int         cmd0;
        int         wr0;
        logic [7:0] r;

        // Reset values.
        #10;
        chk_all_zero("reset");
        #10;
        rst_n = 1'b1;
        #50;

        // ECHO frame.
        rx0 = rx_cnt; cmd0 = cmd_cnt;
        run_frame(3, 8'h01, 8'h3C, 8'hC3);
        chk("echo_rx_pulses", 32'(rx_cnt - rx0), 32'd2);
        chk("echo_cmd_pulses", 32'(cmd_cnt - cmd0), 32'd1);
        chk("echo_err", 32'(err_count), 32'(m_err));

        // WRITE then READ.
        wr0 = wr_cnt;
        run_frame(2, 8'h02, 8'h5A);
        chk("wr_ctrl_reg", 32'(ctrl_reg), 32'(m_ctrl));
        chk("wr_pulses", 32'(wr_cnt - wr0), 32'd1);
        run_frame(2, 8'h03, 8'h00);
        chk("rd_ctrl_reg", 32'(ctrl_reg), 32'h5A);
        chk("rd_err", 32'(err_count), 32'd0);

        // Unknown opcode.
        rx0 = rx_cnt;
        run_frame(2, 8'h7E, 8'h11);
        chk("bad_op_err", 32'(err_count), 32'(m_err));
        chk("bad_op_rx_pulses", 32'(rx_cnt - rx0), 32'd0);

        // Abort after 5 bits of the second data byte.
        rx0 = rx_cnt;
        model_frame(2, 8'h01, 8'h3C, 8'h00);
        cs_low();
        xfer_checked(8'h01);
        xfer_checked(8'h3C);
        spi_bits(8'hC3, 5, r);
        cs_high();
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
        chk("abort_rx_pulses", 32'(rx_cnt - rx0), 32'd1);
        chk("abort_err", 32'(err_count), 32'(m_err));
        run_frame(2, 8'h01, 8'h3C);
        chk("post_abort_err", 32'(err_count), 32'(m_err));

        // Reset mid-byte with cs held low.
        exp_cmd = 8'h01;
        cs_low();
        spi_bits(8'h01, 8, r);
        spi_bits(8'h3C, 4, r);
        rst_n = 1'b0;
        #20;
        chk_all_zero("midrst");
        m_ctrl = 8'h00;
        m_err  = 8'h00;
        rst_n  = 1'b1;
        #40;
        rx0 = rx_cnt; cmd0 = cmd_cnt;
        spi_bits(8'h01, 8, r);
        chk("midrst_miso0", 32'(r), 32'd0);
        spi_bits(8'h55, 8, r);
        chk("midrst_miso1", 32'(r), 32'd0);
        chk("midrst_rx_pulses", 32'(rx_cnt - rx0), 32'd0);
        chk("midrst_cmd_pulses", 32'(cmd_cnt - cmd0), 32'd0);
        cs_high();
        run_frame(3, 8'h01, 8'h66, 8'h99);
        chk("midrst_echo_rx_pulses", 32'(rx_cnt - rx0), 32'd2);
        chk("midrst_err", 32'(err_count), 32'd0);

        // Saturation over 300 bad-opcode frames.
        for (int i = 0; i < 300; i++) run_frame(1, 8'h7E);
        chk("sat_err", 32'(err_count), 32'(m_err));
        chk("sat_cmd", 32'(cmd), 32'h7E);
        chk("sat_ctrl_reg", 32'(ctrl_reg), 32'd0);

        #100;
        chk("rx_queue_drained", 32'(rx_exp.size()), 32'd0);
        chk("miso_queue_drained", 32'(miso_exp.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_echo_ctrl.md
Name: spi_echo_ctrl

Overview:
System-clock-domain SPI slave controller for the 8-bit echo bench. It oversamples the raw SPI pins, assembles bytes, decodes the first byte of each frame as a command, and sequences the response on MISO (echo, register write, register read). It sits between the SPI pins and the bench's control and status logic, and replaces free-running sclk-clocked capture with a single-clock design.

Parameters:
WIDTH, 8, byte width in bits (must be at least 4); opcodes and responses are WIDTH wide, zero-extended.
IDLE_RESP, 8'hA5, value shifted out during the command byte.
ERR_RESP, 8'hFF, value shifted out after an unknown opcode.

Ports:
clk  input  1  system clock; must be at least 8x the sclk frequency.
rst_n  input  1  asynchronous active-low reset.
spi_sclk  input  1  raw SPI clock; CPOL=0; MOSI sampled on sclk falling edge.
spi_cs  input  1  raw chip select, active low.
spi_mosi  input  1  raw master-out data, MSB first.
spi_miso  output  1  slave-out data, MSB first, updated on sclk rising edge.
rx_data  output  WIDTH  last completed data byte (not the command byte).
rx_valid  output  1  one-cycle pulse when rx_data updates.
cmd  output  WIDTH  last received command byte.
cmd_valid  output  1  one-cycle pulse when cmd updates.
ctrl_reg  output  WIDTH  control register, written by the WRITE command.
reg_wr  output  1  one-cycle pulse when ctrl_reg is written.
err_count  output  8  saturating count of unknown opcodes plus aborted partial bytes.

Behaviour:
- Reset: all outputs are 0 and spi_miso is 0. FSM goes to IDLE. bit_cnt=0, rx_shift=0, tx_shift=0.
- Synchronisation:
  - Each of sclk, cs and mosi passes through a 2-FF synchroniser, plus one history FF for edge detection on sclk and cs.
  - fall = sclk_prev & ~sclk_s; rise = ~sclk_prev & sclk_s; cs_on = ~cs_s.
  - Latency from pin to detected edge is 3 clk.
- RX path, on fall while cs_on:
  - rx_shift <= {rx_shift[WIDTH-2:0], mosi_s}; bit_cnt increments.
  - When bit_cnt==WIDTH-1: bit_cnt wraps to 0 and byte_done pulses the next clk with byte = completed rx_shift.
- TX path:
  - On rise while cs_on: spi_miso <= tx_shift[WIDTH-1]; tx_shift shifts left and fills with 0.
  - tx_shift is reloaded at byte_done, before the next rise.
- FSM states: IDLE, CMD, ECHO, WR, RD, DONE, IGNORE. All transitions below happen on byte_done unless stated otherwise.
- IDLE: on cs falling edge -> CMD; tx_shift <= IDLE_RESP; bit_cnt=0.
- CMD: cmd <= byte; cmd_valid pulses. Decode:
  - 0x01 -> ECHO, tx <= 0x01.
  - 0x02 -> WR, tx <= 0x02.
  - 0x03 -> RD, tx <= ctrl_reg.
  - any other value -> IGNORE, tx <= ERR_RESP, err_count increments.
- ECHO: rx_data <= byte; rx_valid pulses; tx <= byte, so each byte is echoed during the following byte. Stays in ECHO.
- WR: ctrl_reg <= byte; reg_wr pulses; rx_data <= byte; rx_valid pulses; tx <= byte -> DONE.
- RD: rx_data <= byte; rx_valid pulses; tx <= 0 -> DONE.
- DONE: bytes are ignored; tx <= 0. IGNORE: bytes are ignored; tx <= ERR_RESP. Neither state pulses rx_valid.
- cs deassert (rising cs_s) in any state:
  - FSM -> IDLE; bit_cnt, rx_shift and tx_shift are cleared; spi_miso <= 0.
  - If bit_cnt != 0, the partial byte is discarded and err_count increments. No rx_valid for the partial byte.
- Simultaneous events:
  - cs deassert and sclk edge in the same clk: the deassert wins and the edge is ignored.
  - byte_done and cs deassert in the same clk: byte_done is processed first (pulses are still issued), then IDLE is entered.
- err_count saturates at 8'hFF. If two increments fall in the same clk (unknown opcode in CMD plus a cs abort), it increments once.
- Reset mid-frame: state is cleared. If cs is already low when rst_n releases, the frame is ignored until cs goes high and then low again. No edge is inferred from the synchroniser reset values.
- ctrl_reg changes only via WR or rst_n.

Test Plan:
- Frame {0x01, 0x3C, 0xC3}: MISO returns {0xA5, 0x01, 0x3C}; cmd=0x01 with one cmd_valid; two rx_valid pulses with rx_data 0x3C then 0xC3.
- Frame {0x02, 0x5A}, then frame {0x03, 0x00}: ctrl_reg=0x5A with one reg_wr; second frame MISO returns {0xA5, 0x5A}; err_count=0.
- Frame {0x7E, 0x11}: MISO returns {0xA5, 0xFF}; err_count=1; no rx_valid.
- cs deasserted after 5 bits of the second byte of an ECHO frame: no rx_valid for it; err_count +1; next frame starts cleanly and returns 0xA5 first.
- rst_n pulsed mid-byte with cs held low: all outputs 0; bytes ignored until a cs high-low cycle, after which an ECHO frame behaves normally.
- 300 unknown-opcode frames: err_count saturates at 0xFF; sclk at clk/8 produces no missed bits.
